// File: rtl/mem_access_pkg.sv
`timescale 1ns/1ps
// Shared defines for the memory-access stage: instruction fields, opcodes, FSM encoding,
// lane/load types and the data-memory request payload.
package mem_access_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned ILEN       = 32;
    localparam int unsigned AW         = 32;
    localparam int unsigned DW         = 32;
    localparam int unsigned BEW        = DW / 8;
    localparam int unsigned OPC_MSB    = 31;
    localparam int unsigned OPC_LSB    = 26;
    localparam int unsigned OPC_W      = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned WAIT_CNT_W = 10;

    localparam logic [OPC_W-1:0] OPC_LB  = 6'h20;
    localparam logic [OPC_W-1:0] OPC_LH  = 6'h21;
    localparam logic [OPC_W-1:0] OPC_LW  = 6'h23;
    localparam logic [OPC_W-1:0] OPC_LBU = 6'h24;
    localparam logic [OPC_W-1:0] OPC_LHU = 6'h25;
    localparam logic [OPC_W-1:0] OPC_SB  = 6'h28;
    localparam logic [OPC_W-1:0] OPC_SH  = 6'h29;
    localparam logic [OPC_W-1:0] OPC_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5
    } ld_type_e;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [BEW-1:0] be;
        logic [DW-1:0]  wdata;
        logic           we;
    } mem_req_t;

    typedef struct packed {
        logic      valid;
        logic      we;
        mem_size_e size;
        ld_type_e  ld_type;
    } op_dec_t;

    // Opcode decode; stores carry LD_NONE so their load_data reads back as zero.
    function automatic op_dec_t decode_op(input logic [OPC_W-1:0] opc);
        op_dec_t d;
        d = '{valid: 1'b0, we: 1'b0, size: SZ_W, ld_type: LD_NONE};
        case (opc)
            OPC_LB:  d = '{valid: 1'b1, we: 1'b0, size: SZ_B, ld_type: LD_B};
            OPC_LH:  d = '{valid: 1'b1, we: 1'b0, size: SZ_H, ld_type: LD_H};
            OPC_LW:  d = '{valid: 1'b1, we: 1'b0, size: SZ_W, ld_type: LD_W};
            OPC_LBU: d = '{valid: 1'b1, we: 1'b0, size: SZ_B, ld_type: LD_BU};
            OPC_LHU: d = '{valid: 1'b1, we: 1'b0, size: SZ_H, ld_type: LD_HU};
            OPC_SB:  d = '{valid: 1'b1, we: 1'b1, size: SZ_B, ld_type: LD_NONE};
            OPC_SH:  d = '{valid: 1'b1, we: 1'b1, size: SZ_H, ld_type: LD_NONE};
            OPC_SW:  d = '{valid: 1'b1, we: 1'b1, size: SZ_W, ld_type: LD_NONE};
            default: d = '{valid: 1'b0, we: 1'b0, size: SZ_W, ld_type: LD_NONE};
        endcase
        return d;
    endfunction

    // Force the low address bits to the natural alignment of the access size.
    function automatic logic [1:0] align_lo(input mem_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    return {lo[1], 1'b0};
            SZ_W:    return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
`timescale 1ns/1ps
// Execute-stage and data-memory signals of the memory-access stage.
// slave: the mem_access block; master: the pipeline/memory side driving it.
interface mem_access_if;
    import mem_access_pkg::*;

    logic            valid_in;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] alu_result;
    logic [DW-1:0]   rt;
    logic            stall;
    logic            dmem_req;
    logic            dmem_we;
    logic [AW-1:0]   dmem_addr;
    logic [BEW-1:0]  dmem_be;
    logic [DW-1:0]   dmem_wdata;
    logic [DW-1:0]   dmem_rdata;
    logic            dmem_ack;
    logic            done;
    logic [DW-1:0]   load_data;
    logic            err;

    modport master (
        output valid_in, inst, alu_result, rt, dmem_rdata, dmem_ack,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, done, load_data, err
    );

    modport slave (
        input  valid_in, inst, alu_result, rt, dmem_rdata, dmem_ack,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, done, load_data, err
    );

endinterface

// File: rtl/mem_lane_align.sv
`timescale 1ns/1ps
// Byte-lane steering: store byte enables and data replication, load extraction and extension.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  mem_size_e      size_i,
    input  logic [1:0]     addr_lo_i,
    input  logic [DW-1:0]  st_data_i,
    output logic [BEW-1:0] be_c_o,
    output logic [DW-1:0]  wdata_c_o,
    input  ld_type_e       ld_type_i,
    input  logic [1:0]     ld_lo_i,
    input  logic [DW-1:0]  ld_rdata_i,
    output logic [DW-1:0]  ld_data_c_o
);

    logic [15:0] ld_half;

    always_comb begin
        be_c_o    = '1;
        wdata_c_o = st_data_i;
        case (size_i)
            SZ_B: begin
                be_c_o    = BEW'(4'b0001 << addr_lo_i);
                wdata_c_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                be_c_o    = BEW'(4'b0011 << addr_lo_i);
                wdata_c_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Addressed lane shifted down to bit 0 before extension.
    assign ld_half = 16'(ld_rdata_i >> {ld_lo_i, 3'b000});

    always_comb begin
        ld_data_c_o = '0;
        case (ld_type_i)
            LD_B:    ld_data_c_o = {{24{ld_half[7]}}, ld_half[7:0]};
            LD_BU:   ld_data_c_o = {24'h0, ld_half[7:0]};
            LD_H:    ld_data_c_o = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_data_c_o = {16'h0, ld_half};
            LD_W:    ld_data_c_o = ld_rdata_i;
            default: ld_data_c_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
`timescale 1ns/1ps
// Memory-access stage: issues one data-memory request per supported load/store and waits for ack.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses raise err instead of being force-aligned.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic         clk_cpu,
    input logic         reset,
    mem_access_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t              req_q, req_d;
    logic                  dreq_q, dreq_d;
    logic [1:0]            lo_q, lo_d;
    ld_type_e              ldt_q, ldt_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [OPC_W-1:0] opc;
    logic [AW-1:0]    addr;
    op_dec_t          dec;
    logic [1:0]       lo_al;
    logic             accept;
    logic             misalign_err;
    logic             stall_c;
    logic [BEW-1:0]   be_c;
    logic [DW-1:0]    wdata_c;
    logic [DW-1:0]    ld_data_c;
    logic             unused_bits;

    assign opc         = bus.inst[OPC_MSB:OPC_LSB];
    assign addr        = bus.alu_result[AW-1:0];
    assign dec         = decode_op(opc);
    assign lo_al       = align_lo(dec.size, addr[1:0]);
    assign accept      = bus.valid_in && dec.valid;
    assign unused_bits = ^{bus.inst[OPC_LSB-1:0], bus.alu_result[XLEN-1:AW]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_err = ((dec.size == SZ_H) && addr[0]) ||
                          ((dec.size == SZ_W) && (addr[1:0] != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

    mem_lane_align u_lane (
        .size_i      (dec.size),
        .addr_lo_i   (lo_al),
        .st_data_i   (bus.rt),
        .be_c_o      (be_c),
        .wdata_c_o   (wdata_c),
        .ld_type_i   (ldt_q),
        .ld_lo_i     (lo_q),
        .ld_rdata_i  (rdata_q),
        .ld_data_c_o (ld_data_c)
    );

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            dreq_q  <= 1'b0;
            lo_q    <= 2'b00;
            ldt_q   <= LD_NONE;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            dreq_q  <= dreq_d;
            lo_q    <= lo_d;
            ldt_q   <= ldt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Request payload is cleared on leaving WAIT so the bus is quiet between accesses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        dreq_d  = 1'b0;
        lo_d    = lo_q;
        ldt_d   = ldt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall_c = 1'b1;
                    if (misalign_err) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        ldt_d   = LD_NONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                        dreq_d  = 1'b1;
                        req_d   = '{addr: {addr[AW-1:2], 2'b00}, be: be_c, wdata: wdata_c, we: dec.we};
                        lo_d    = lo_al;
                        ldt_d   = dec.ld_type;
                    end
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (bus.dmem_ack) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    rdata_d = bus.dmem_rdata;
                    req_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    req_d   = '0;
                end else begin
                    cnt_d  = cnt_q + WAIT_CNT_W'(1);
                    dreq_d = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Accept-cycle stall is combinational; masked so it reads 0 while reset is held.
    assign bus.stall      = stall_c && reset;
    assign bus.dmem_req   = dreq_q;
    assign bus.dmem_we    = req_q.we;
    assign bus.dmem_addr  = req_q.addr;
    assign bus.dmem_be    = req_q.be;
    assign bus.dmem_wdata = req_q.wdata;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.load_data  = done_q ? ld_data_c : '0;

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
// Directed bench for mem_access (TIMEOUT_CYCLES=4): loads, stores, ignored opcodes,
// ack delay, timeout, misalignment and reset during WAIT.
module tb_mem_access;

    logic clk_cpu = 1'b0;
    logic reset   = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    logic [31:0] c_addr, c_wdata, c_ld;
    logic [3:0]  c_be;
    logic        c_req, c_we, c_done, c_err;

    mem_access_if bus();

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk_cpu (clk_cpu),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] opc, input logic [31:0] a, input logic [31:0] d);
        bus.valid_in   = v;
        bus.inst       = {opc, 26'h155_5555};
        bus.alu_result = {32'hCAFE_F00D, a};
        bus.rt         = d;
    endtask

    // Runs one access with ack in the first WAIT cycle; records the request and the response.
    task automatic xact(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
        drive(1'b1, opc, a, d);
        bus.dmem_ack = 1'b0;
        tick();
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        c_req = bus.dmem_req; c_addr = bus.dmem_addr; c_be = bus.dmem_be;
        c_wdata = bus.dmem_wdata; c_we = bus.dmem_we;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = rd;
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        c_done = bus.done; c_err = bus.err; c_ld = bus.load_data;
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 6'h23, 32'h1000, 32'hFFFF_FFFF);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        n_cmp++; if ({bus.stall, bus.dmem_req, bus.dmem_we, bus.done, bus.err} !== 5'b0) begin n_fail++;
            $display("FAIL rst_flags: got %b want 00000", {bus.stall, bus.dmem_req, bus.dmem_we, bus.done, bus.err}); end
        n_cmp++; if ({bus.dmem_addr, bus.dmem_wdata, bus.load_data} !== 96'h0) begin n_fail++;
            $display("FAIL rst_data: got %h want 0", {bus.dmem_addr, bus.dmem_wdata, bus.load_data}); end
        n_cmp++; if (bus.dmem_be !== 4'h0) begin n_fail++; $display("FAIL rst_be: got %h want 0", bus.dmem_be); end
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        @(negedge clk_cpu); reset = 1'b1;
        tick();
        n_cmp++; if ({bus.stall, bus.dmem_req, bus.done} !== 3'b0) begin n_fail++;
            $display("FAIL rst_release: got %b want 000", {bus.stall, bus.dmem_req, bus.done}); end
    endtask

    task automatic test_lw();
        drive(1'b1, 6'h23, 32'h1000, 32'h0);
        bus.dmem_ack = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lw_accept_stall: got %b want 1", bus.stall); end
        tick();
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        n_cmp++; if ({bus.dmem_req, bus.dmem_we, bus.stall, bus.done} !== 4'b1010) begin n_fail++;
            $display("FAIL lw_wait_flags: got %b want 1010", {bus.dmem_req, bus.dmem_we, bus.stall, bus.done}); end
        n_cmp++; if (bus.dmem_addr !== 32'h1000) begin n_fail++; $display("FAIL lw_addr: got %h want 00001000", bus.dmem_addr); end
        n_cmp++; if (bus.dmem_be !== 4'hF) begin n_fail++; $display("FAIL lw_be: got %h want f", bus.dmem_be); end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.dmem_ack = 1'b0;
        n_cmp++; if ({bus.done, bus.err, bus.stall, bus.dmem_req} !== 4'b1000) begin n_fail++;
            $display("FAIL lw_resp_flags: got %b want 1000", {bus.done, bus.err, bus.stall, bus.dmem_req}); end
        n_cmp++; if (bus.load_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", bus.load_data); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL lw_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_lb_lh();
        xact(6'h20, 32'h1003, 32'h0, 32'h80FF_FF00);
        n_cmp++; if ({c_be, c_addr} !== {4'b1000, 32'h1000}) begin n_fail++; $display("FAIL lb_req: got %h/%h want 8/00001000", c_be, c_addr); end
        n_cmp++; if ({c_done, c_ld} !== {1'b1, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL lb_data: got %b/%h want 1/ffffff80", c_done, c_ld); end
        xact(6'h24, 32'h1003, 32'h0, 32'h80FF_FF00);
        n_cmp++; if (c_be !== 4'b1000) begin n_fail++; $display("FAIL lbu_be: got %b want 1000", c_be); end
        n_cmp++; if ({c_done, c_ld} !== {1'b1, 32'h0000_0080}) begin n_fail++; $display("FAIL lbu_data: got %b/%h want 1/00000080", c_done, c_ld); end
        xact(6'h21, 32'h1002, 32'h0, 32'h80FF_FF00);
        n_cmp++; if ({c_be, c_ld} !== {4'b1100, 32'hFFFF_80FF}) begin n_fail++; $display("FAIL lh: got %b/%h want 1100/ffff80ff", c_be, c_ld); end
        xact(6'h25, 32'h1002, 32'h0, 32'h80FF_FF00);
        n_cmp++; if ({c_be, c_ld} !== {4'b1100, 32'h0000_80FF}) begin n_fail++; $display("FAIL lhu: got %b/%h want 1100/000080ff", c_be, c_ld); end
    endtask

    task automatic test_store();
        xact(6'h29, 32'h2002, 32'h1234_ABCD, 32'h0);
        n_cmp++; if ({c_req, c_we, c_be, c_addr} !== {1'b1, 1'b1, 4'b1100, 32'h2000}) begin n_fail++;
            $display("FAIL sh_req: got %b%b/%b/%h want 11/1100/00002000", c_req, c_we, c_be, c_addr); end
        n_cmp++; if (c_wdata[31:16] !== 16'hABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcd", c_wdata[31:16]); end
        n_cmp++; if ({c_done, c_err} !== 2'b10) begin n_fail++; $display("FAIL sh_done: got %b want 10", {c_done, c_err}); end
        xact(6'h28, 32'h2001, 32'h1234_5677, 32'h0);
        n_cmp++; if ({c_we, c_be, c_wdata} !== {1'b1, 4'b0010, 32'h7777_7777}) begin n_fail++;
            $display("FAIL sb_req: got %b/%b/%h want 1/0010/77777777", c_we, c_be, c_wdata); end
        xact(6'h2B, 32'h2004, 32'h0102_0304, 32'h0);
        n_cmp++; if ({c_be, c_addr, c_wdata} !== {4'hF, 32'h2004, 32'h0102_0304}) begin n_fail++;
            $display("FAIL sw_req: got %h/%h/%h want f/00002004/01020304", c_be, c_addr, c_wdata); end
    endtask

    task automatic test_unsupported();
        logic [5:0] ops [6];
        ops = '{6'h00, 6'h22, 6'h26, 6'h2A, 6'h2C, 6'h3F};
        foreach (ops[i]) begin
            drive(1'b1, ops[i], 32'h3000, 32'h0);
            #1;
            n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL unsup_stall op=%h: got %b want 0", ops[i], bus.stall); end
            tick();
            n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL unsup_req op=%h: got %b want 0", ops[i], bus.dmem_req); end
        end
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_2222;
        tick();
        bus.dmem_ack = 1'b0;
        tick();
        n_cmp++; if ({bus.done, bus.err, bus.dmem_req} !== 3'b000) begin n_fail++;
            $display("FAIL idle_ack_ignored: got %b want 000", {bus.done, bus.err, bus.dmem_req}); end
    endtask

    task automatic test_ack_delay();
        drive(1'b1, 6'h23, 32'h5008, 32'h0);
        bus.dmem_ack = 1'b0;
        tick();
        drive(1'b1, 6'h2B, 32'h6000, 32'h9999_9999);
        tick();
        n_cmp++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.done} !== {2'b10, 32'h5008, 1'b0}) begin n_fail++;
            $display("FAIL delay_hold: got %b%b/%h/%b want 10/00005008/0", bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.done); end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hA5A5_0001;
        tick();
        bus.dmem_ack = 1'b0;
        n_cmp++; if ({bus.done, bus.load_data} !== {1'b1, 32'hA5A5_0001}) begin n_fail++;
            $display("FAIL delay_done: got %b/%h want 1/a5a50001", bus.done, bus.load_data); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL resp_stall: got %b want 0", bus.stall); end
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_timeout();
        drive(1'b1, 6'h23, 32'h3000, 32'h0);
        bus.dmem_ack = 1'b0;
        tick();
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if ({bus.dmem_req, bus.err} !== 2'b10) begin n_fail++;
                $display("FAIL timeout_wait%0d: got %b want 10", i, {bus.dmem_req, bus.err}); end
            tick();
        end
        n_cmp++; if ({bus.err, bus.done, bus.dmem_req, bus.stall} !== 4'b1000) begin n_fail++;
            $display("FAIL timeout_err: got %b want 1000", {bus.err, bus.done, bus.dmem_req, bus.stall}); end
        n_cmp++; if (bus.load_data !== 32'h0) begin n_fail++; $display("FAIL timeout_data: got %h want 0", bus.load_data); end
        tick();
        n_cmp++; if ({bus.err, bus.dmem_req} !== 2'b00) begin n_fail++; $display("FAIL timeout_idle: got %b want 00", {bus.err, bus.dmem_req}); end
    endtask

    task automatic test_ack_at_limit();
        drive(1'b1, 6'h23, 32'h3004, 32'h0);
        bus.dmem_ack = 1'b0;
        tick();
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        tick(); tick(); tick();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h55AA_55AA;
        tick();
        bus.dmem_ack = 1'b0;
        n_cmp++; if ({bus.done, bus.err, bus.load_data} !== {2'b10, 32'h55AA_55AA}) begin n_fail++;
            $display("FAIL ack_at_limit: got %b%b/%h want 10/55aa55aa", bus.done, bus.err, bus.load_data); end
        tick();
    endtask

    task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
        drive(1'b1, 6'h23, 32'h1001, 32'h0);
        bus.dmem_ack = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL mis_stall: got %b want 1", bus.stall); end
        tick();
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        n_cmp++; if ({bus.err, bus.done, bus.dmem_req} !== 3'b100) begin n_fail++;
            $display("FAIL mis_err: got %b want 100", {bus.err, bus.done, bus.dmem_req}); end
        tick();
        n_cmp++; if ({bus.err, bus.dmem_req} !== 2'b00) begin n_fail++; $display("FAIL mis_idle: got %b want 00", {bus.err, bus.dmem_req}); end
`else
        xact(6'h23, 32'h1001, 32'h0, 32'h1122_3344);
        n_cmp++; if ({c_req, c_addr, c_be} !== {1'b1, 32'h1000, 4'hF}) begin n_fail++;
            $display("FAIL mis_lw_req: got %b/%h/%h want 1/00001000/f", c_req, c_addr, c_be); end
        n_cmp++; if ({c_done, c_err, c_ld} !== {2'b10, 32'h1122_3344}) begin n_fail++;
            $display("FAIL mis_lw_done: got %b%b/%h want 10/11223344", c_done, c_err, c_ld); end
        xact(6'h21, 32'h1003, 32'h0, 32'h80FF_FF00);
        n_cmp++; if ({c_be, c_ld} !== {4'b1100, 32'hFFFF_80FF}) begin n_fail++;
            $display("FAIL mis_lh: got %b/%h want 1100/ffff80ff", c_be, c_ld); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        drive(1'b1, 6'h23, 32'h4000, 32'h0);
        bus.dmem_ack = 1'b0;
        tick();
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        n_cmp++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmw_req: got %b want 1", bus.dmem_req); end
        #2; reset = 1'b0; #1;
        n_cmp++; if ({bus.dmem_req, bus.stall} !== 2'b00) begin n_fail++;
            $display("FAIL rmw_drop: got %b want 00", {bus.dmem_req, bus.stall}); end
        tick();
        n_cmp++; if ({bus.done, bus.err} !== 2'b00) begin n_fail++; $display("FAIL rmw_held: got %b want 00", {bus.done, bus.err}); end
        @(negedge clk_cpu); reset = 1'b1;
        tick();
        n_cmp++; if ({bus.done, bus.err, bus.dmem_req} !== 3'b000) begin n_fail++;
            $display("FAIL rmw_release: got %b want 000", {bus.done, bus.err, bus.dmem_req}); end
        xact(6'h23, 32'h4004, 32'h0, 32'h0BAD_F00D);
        n_cmp++; if ({c_req, c_addr, c_done, c_ld} !== {1'b1, 32'h4004, 1'b1, 32'h0BAD_F00D}) begin n_fail++;
            $display("FAIL rmw_new_lw: got %b/%h/%b/%h want 1/00004004/1/0badf00d", c_req, c_addr, c_done, c_ld); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lh();
        test_store();
        test_unsupported();
        test_ack_delay();
        test_timeout();
        test_ack_at_limit();
        test_misaligned();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum wait in WAIT for dmem_ack before a bus error; range 1..1023.
REQ-002 clk_cpu  input  1  CPU clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 valid_in  input  1  execute-stage instruction valid this cycle.
REQ-005 inst  input  32  instruction word; opcode inst[31:26] selects the memory operation.
REQ-006 alu_result  input  64  ALU result; the effective address is alu_result[31:0].
REQ-007 rt  input  32  store data, in bits [7:0] for sb, [15:0] for sh and [31:0] for sw.
REQ-008 stall  output  1  holds the upstream pipeline stages.
REQ-009 dmem_req, dmem_we  output  1 each  data-memory request and write strobe.
REQ-010 dmem_addr  output  32  word-aligned address, with bits [1:0] = 0.
REQ-011 dmem_be  output  4  byte enables; lane n = bits [8n+7:8n], little-endian.
REQ-012 dmem_wdata  output  32  store data replicated onto the addressed lanes.
REQ-013 dmem_rdata  input  32; dmem_ack  input  1  read data and completion strobe from data memory.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 load_data  output  32  extended load result, valid when done=1.
REQ-016 err  output  1  one-cycle error pulse, asserted in place of done.

Function
REQ-017 Supported opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B; every other opcode shall be ignored, with stall=0 and no request issued.
REQ-018 FSM states: IDLE, WAIT and RESP.
- IDLE -> WAIT when valid_in=1 and the opcode is supported.
- WAIT -> RESP on dmem_ack=1, or when the timeout is reached.
- RESP -> IDLE always, after one cycle.
REQ-019 On the IDLE->WAIT transition, the address, byte enables, write data, write flag and load type shall be registered.
REQ-020 dmem_req shall be 1 exactly while in WAIT, and all dmem_* outputs shall be stable throughout WAIT.
REQ-021 stall shall be asserted in two cases:
- combinationally in IDLE when the accept condition holds;
- for the whole of WAIT.
stall shall be 0 in RESP.
REQ-022 Byte enables shall be 4'b0001<<a[1:0] for byte operations, 4'b0011<<a[1:0] for halfword operations and 4'b1111 for word operations.
REQ-023 Load data shall be captured on the cycle in which dmem_ack=1 in WAIT. In RESP, the addressed byte or halfword shall be shifted down and then sign-extended (lb, lh) or zero-extended (lbu, lhu).
REQ-024 Minimum latency from accept to done shall be 2 cycles, with dmem_ack arriving in the first WAIT cycle. Each additional cycle of ack delay shall add 1 cycle.
REQ-025 A 10-bit wait counter shall clear on entry to WAIT and increment each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES without ack, the FSM shall go to RESP with err=1, done=0 and load_data=0.
REQ-026 If dmem_ack arrives on the same cycle the counter reaches the limit, ack shall win and no error shall be raised.
REQ-027 dmem_ack received outside WAIT shall be ignored.
REQ-028 valid_in received outside IDLE shall be ignored; upstream holds the instruction because stall is asserted.

Reset
REQ-029 While reset=0, the block shall go to IDLE immediately, regardless of the clock.
REQ-030 During reset, all outputs shall be 0: stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, done, load_data and err.
REQ-031 Reset during WAIT shall abandon the transaction with no done or err pulse; the memory side shall tolerate the request being dropped.

Configuration
REQ-032 With MEM_ALIGN_CHECK_EN defined, a misaligned access shall not be issued and shall go IDLE->RESP directly with err=1. Misaligned means a halfword with a[0]=1, or a word with a[1:0]!=0.
REQ-033 Without MEM_ALIGN_CHECK_EN, the low address bits shall be forced to alignment (a[0] cleared for halfword operations, a[1:0] cleared for word operations) and the access shall proceed normally.

Structure
REQ-034 The opcode constants, the FSM state encoding and a load-type enum shall live in the shared defines package alongside the existing ALU and instruction-field macros.
REQ-035 Byte-lane steering (byte enables, write-data replication, load extraction and extension) shall be one combinational sub-module named mem_lane_align, instantiated once.

Verification
REQ-036 Bench scenario, lw: addr 0x1000, ack on the first WAIT cycle, rdata 0xDEADBEEF -> dmem_be=4'hF, done 2 cycles after accept, load_data=0xDEADBEEF.
REQ-037 Bench scenario, lb and lbu: addr 0x1003, rdata 0x80FF_FF00.
- lb -> be=4'b1000, load_data=0xFFFFFF80.
- lbu -> be=4'b1000, load_data=0x00000080.
REQ-038 Bench scenario, sh: addr 0x2002, rt=0x1234ABCD -> be=4'b1100, wdata[31:16]=0xABCD, we=1, done pulse.
REQ-039 Bench scenario, timeout: TIMEOUT_CYCLES=4, ack never arrives -> err pulse after 4 WAIT cycles, done=0, IDLE afterwards.
REQ-040 Bench scenario, misaligned lw at 0x1001:
- with MEM_ALIGN_CHECK_EN -> err with no dmem_req;
- without it -> dmem_addr=0x1000 and a normal done.
REQ-041 Bench scenario, reset: reset=0 asserted mid-WAIT -> dmem_req drops immediately, no done or err; after release, a new lw completes normally.
